// File: rtl/arp_eth_tx.sv
// ARP frame transmitter: latches one ARP frame and emits an Ethernet header
// plus the 28-byte ARP payload as an AXI stream.
module arp_eth_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy
);

  localparam int CC     = (28 + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int OFFSET = 28 % KEEP_WIDTH;
  localparam int PW     = (CC > 1) ? $clog2(CC) : 1;
  localparam int SW     = CC * DATA_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(CC - 1);
  localparam logic [KEEP_WIDTH-1:0] LAST_KEEP =
    (OFFSET != 0) ? KEEP_WIDTH'((1 << OFFSET) - 1)
                  : {KEEP_WIDTH{1'b1}};

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q;
  logic            ready_q;
  logic            hdr_valid_q;
  logic            tvalid_q;
  logic            busy_q;
  logic            hdr_done_q;
  logic            pay_done_q;
  logic [PW-1:0]   ptr_q;
  logic [SW-1:0]   shreg_q;
  logic [SW-1:0]   shreg_d;
  logic [47:0]     dest_q;
  logic [47:0]     src_q;
  logic [15:0]     type_q;

  logic [223:0]    be;
  logic [223:0]    le;
  logic            hdr_hs;
  logic            beat_hs;
  logic            last_hs;
  logic            done;
  logic            tlast;

  assign be = {s_arp_htype, s_arp_ptype, 8'h06, 8'h04, s_arp_oper,
               s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};

  // Payload byte 0 lands in the low lane, so the stream is a right shift.
  always_comb begin
    le = '0;
    for (int k = 0; k < 28; k++) begin
      le[8*k +: 8] = be[223-8*k -: 8];
    end
  end

  assign shreg_d = shreg_q >> DATA_WIDTH;

  assign hdr_hs  = hdr_valid_q && m_eth_hdr_ready;
  assign beat_hs = tvalid_q && m_eth_payload_axis_tready;
  assign last_hs = beat_hs && (ptr_q == LAST);
  assign done    = (hdr_done_q || hdr_hs) && (pay_done_q || last_hs);
  assign tlast   = tvalid_q && (ptr_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      hdr_done_q  <= 1'b0;
      pay_done_q  <= 1'b0;
      ptr_q       <= '0;
      shreg_q     <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (s_frame_valid && ready_q) begin
            dest_q      <= s_eth_dest_mac;
            src_q       <= s_eth_src_mac;
            type_q      <= s_eth_type;
            shreg_q     <= SW'(le);
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            hdr_valid_q <= 1'b1;
            tvalid_q    <= 1'b1;
            hdr_done_q  <= 1'b0;
            pay_done_q  <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (hdr_hs) begin
            hdr_valid_q <= 1'b0;
            hdr_done_q  <= 1'b1;
          end
          if (last_hs) begin
            tvalid_q   <= 1'b0;
            pay_done_q <= 1'b1;
          end else if (beat_hs) begin
            ptr_q   <= ptr_q + PW'(1);
            shreg_q <= shreg_d;
          end
          if (done) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_frame_ready             = ready_q;
  assign m_eth_hdr_valid           = hdr_valid_q;
  assign m_eth_dest_mac            = dest_q;
  assign m_eth_src_mac             = src_q;
  assign m_eth_type                = type_q;
  assign m_eth_payload_axis_tdata  = shreg_q[DATA_WIDTH-1:0];
  assign m_eth_payload_axis_tkeep  =
    ((KEEP_ENABLE != 0) && tlast) ? LAST_KEEP : {KEEP_WIDTH{1'b1}};
  assign m_eth_payload_axis_tvalid = tvalid_q;
  assign m_eth_payload_axis_tlast  = tlast;
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign busy                      = busy_q;

endmodule

// File: tb/tb_arp_eth_tx.sv
// Directed bench for arp_eth_tx: 8-, 32- and 64-bit payload widths,
// stalls, late header accept and mid-frame reset.
module tb_arp_eth_tx;

  logic clk;
  logic rst_n;

  logic [47:0] dmac = 48'hFFFF_FFFF_FFFF;
  logic [47:0] smac = 48'h0200_0000_0001;
  logic [15:0] etyp = 16'h0806;
  logic [15:0] htyp = 16'h0001;
  logic [15:0] ptyp = 16'h0800;
  logic [15:0] oper = 16'h0001;
  logic [47:0] sha  = 48'h0200_0000_0001;
  logic [31:0] spa  = 32'hC0A8_010A;
  logic [47:0] tha  = 48'h0A0B_0C0D_0E0F;
  logic [31:0] tpa  = 32'hC0A8_0101;

  logic [7:0] expb [28] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8,
    8'h01, 8'h0A, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
    8'hC0, 8'hA8, 8'h01, 8'h01};

  int checks = 0;
  int fails  = 0;

  // 8-bit instance
  logic v8, r8, hv8, hr8, tv8, tr8, tl8, tu8, b8;
  logic [47:0] dm8, sm8;
  logic [15:0] ty8;
  logic [7:0] td8;
  logic [0:0] tk8;

  // 64-bit instance
  logic v64, r64, hv64, tv64, tl64, tu64, b64;
  logic [47:0] dm64, sm64;
  logic [15:0] ty64;
  logic [63:0] td64;
  logic [7:0] tk64;

  // 32-bit instance
  logic v32, r32, hv32, tv32, tl32, tu32, b32;
  logic [47:0] dm32, sm32;
  logic [15:0] ty32;
  logic [31:0] td32;
  logic [3:0] tk32;

  arp_eth_tx #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .s_frame_valid(v8), .s_frame_ready(r8),
    .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etyp),
    .s_arp_htype(htyp), .s_arp_ptype(ptyp), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth_hdr_valid(hv8), .m_eth_hdr_ready(hr8),
    .m_eth_dest_mac(dm8), .m_eth_src_mac(sm8), .m_eth_type(ty8),
    .m_eth_payload_axis_tdata(td8), .m_eth_payload_axis_tkeep(tk8),
    .m_eth_payload_axis_tvalid(tv8), .m_eth_payload_axis_tready(tr8),
    .m_eth_payload_axis_tlast(tl8), .m_eth_payload_axis_tuser(tu8),
    .busy(b8));

  arp_eth_tx #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .s_frame_valid(v64), .s_frame_ready(r64),
    .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etyp),
    .s_arp_htype(htyp), .s_arp_ptype(ptyp), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth_hdr_valid(hv64), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(dm64), .m_eth_src_mac(sm64), .m_eth_type(ty64),
    .m_eth_payload_axis_tdata(td64), .m_eth_payload_axis_tkeep(tk64),
    .m_eth_payload_axis_tvalid(tv64), .m_eth_payload_axis_tready(1'b1),
    .m_eth_payload_axis_tlast(tl64), .m_eth_payload_axis_tuser(tu64),
    .busy(b64));

  arp_eth_tx #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .s_frame_valid(v32), .s_frame_ready(r32),
    .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(etyp),
    .s_arp_htype(htyp), .s_arp_ptype(ptyp), .s_arp_oper(oper),
    .s_arp_sha(sha), .s_arp_spa(spa), .s_arp_tha(tha), .s_arp_tpa(tpa),
    .m_eth_hdr_valid(hv32), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(dm32), .m_eth_src_mac(sm32), .m_eth_type(ty32),
    .m_eth_payload_axis_tdata(td32), .m_eth_payload_axis_tkeep(tk32),
    .m_eth_payload_axis_tvalid(tv32), .m_eth_payload_axis_tready(1'b1),
    .m_eth_payload_axis_tlast(tl32), .m_eth_payload_axis_tuser(tu32),
    .busy(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: random stalls, 2: header held off until payload done
  task automatic run8(input int mode);
    int idx;
    int cyc;
    bit hdone;
    chk("idle_ready8", r8, 1'b1);
    v8 = 1'b1;
    step();
    v8 = (mode == 2);
    chk("hdr_valid_after_accept", hv8, 1'b1);
    chk("tvalid_after_accept", tv8, 1'b1);
    idx = 0;
    hdone = 0;
    cyc = 0;
    while (!(idx == 28 && hdone) && cyc < 400) begin
      case (mode)
        0: begin tr8 = 1'b1; hr8 = 1'b1; end
        1: begin
          tr8 = ($urandom % 3) != 0;
          hr8 = ($urandom % 4) == 0;
        end
        default: begin tr8 = 1'b1; hr8 = (idx == 28); end
      endcase
      chk("ready_low_busy", r8, 1'b0);
      chk("busy_high", b8, 1'b1);
      if (hdone) chk("hdr_valid_dropped", hv8, 1'b0);
      if (idx == 28) chk("tvalid_dropped", tv8, 1'b0);
      if (tv8) begin
        chk($sformatf("byte%0d", idx), td8, expb[idx]);
        chk($sformatf("tlast%0d", idx), tl8, idx == 27);
        chk("tkeep8", tk8, 1'b1);
        chk("tuser8", tu8, 1'b0);
        if (tr8) idx++;
      end
      if (hv8 && hr8) begin
        chk("dest_mac", dm8, dmac);
        chk("src_mac", sm8, smac);
        chk("eth_type", ty8, etyp);
        hdone = 1;
      end
      step();
      cyc++;
    end
    v8 = 1'b0;
    chk("frame_timeout", cyc < 400, 1'b1);
    chk("ready_after_frame", r8, 1'b1);
    chk("busy_after_frame", b8, 1'b0);
    chk("hdr_valid_after_frame", hv8, 1'b0);
    chk("tvalid_after_frame", tv8, 1'b0);
  endtask

  initial begin
    logic [63:0] e;
    logic [63:0] m;
    int beat;
    int cyc;
    rst_n = 1'b0;
    v8 = 0; v64 = 0; v32 = 0;
    hr8 = 0; tr8 = 0;
    #12;
    chk("rst_ready", r8, 1'b0);
    chk("rst_hdr_valid", hv8, 1'b0);
    chk("rst_tvalid", tv8, 1'b0);
    chk("rst_tlast", tl8, 1'b0);
    chk("rst_tuser", tu8, 1'b0);
    chk("rst_busy", b8, 1'b0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", r8, 1'b1);

    run8(0);
    run8(1);
    run8(2);

    // reset in the middle of the payload
    v8 = 1'b1;
    step();
    v8 = 1'b0;
    tr8 = 1'b1;
    hr8 = 1'b0;
    repeat (10) step();
    chk("pre_reset_byte10", td8, expb[10]);
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", tv8, 1'b0);
    chk("midrst_hdr_valid", hv8, 1'b0);
    chk("midrst_busy", b8, 1'b0);
    chk("midrst_tlast", tl8, 1'b0);
    chk("midrst_ready", r8, 1'b0);
    rst_n = 1'b1;
    step();
    chk("ready_after_midrst", r8, 1'b1);
    run8(0);

    // 64-bit: 4 beats, last beat keeps 4 bytes
    chk("idle_ready64", r64, 1'b1);
    v64 = 1'b1;
    step();
    v64 = 1'b0;
    chk("hdr_valid64", hv64, 1'b1);
    chk("beat0_64", td64, 64'h0100_0406_0008_0100);
    beat = 0;
    cyc = 0;
    while (beat < 4 && cyc < 20) begin
      if (tv64) begin
        e = '0;
        m = '0;
        for (int l = 0; l < 8; l++) begin
          if (beat * 8 + l < 28) begin
            e[8*l +: 8] = expb[beat*8+l];
            m[8*l +: 8] = 8'hFF;
          end
        end
        chk($sformatf("data64_b%0d", beat), td64 & m, e);
        chk($sformatf("keep64_b%0d", beat), tk64,
            (beat == 3) ? 8'h0F : 8'hFF);
        chk($sformatf("last64_b%0d", beat), tl64, beat == 3);
        beat++;
      end
      step();
      cyc++;
    end
    chk("frame64_timeout", cyc < 20, 1'b1);
    chk("ready64_after", r64, 1'b1);
    chk("busy64_after", b64, 1'b0);
    chk("tuser64", tu64, 1'b0);

    // 32-bit: 7 beats, no partial beat
    chk("idle_ready32", r32, 1'b1);
    v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("hdr_valid32", hv32, 1'b1);
    chk("beat0_32", td32, 32'h0008_0100);
    beat = 0;
    cyc = 0;
    while (beat < 7 && cyc < 30) begin
      if (tv32) begin
        e = '0;
        for (int l = 0; l < 4; l++) e[8*l +: 8] = expb[beat*4+l];
        chk($sformatf("data32_b%0d", beat), td32, e[31:0]);
        chk($sformatf("keep32_b%0d", beat), tk32, 4'hF);
        chk($sformatf("last32_b%0d", beat), tl32, beat == 6);
        beat++;
      end
      step();
      cyc++;
    end
    chk("frame32_timeout", cyc < 30, 1'b1);
    chk("ready32_after", r32, 1'b1);
    chk("busy32_after", b32, 1'b0);
    chk("eth32_hdr", {dm32[15:0], ty32}, {dmac[15:0], etyp});
    chk("eth64_src", sm64, smac);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
